// File: rtl/tone_env_pwm.sv
// Audio output stage: shapes the divider's square wave with an ADSR envelope
// and drives the mono audio pin as a 256-cycle fixed-frequency PWM stream.
module tone_env_pwm #(
  parameter int TICK_DIV     = 12500,
  parameter int ATTACK_STEP  = 4,
  parameter int DECAY_STEP   = 1,
  parameter int SUSTAIN_LVL  = 160,
  parameter int RELEASE_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  input  logic       gate,
  output logic       pwm_out,
  output logic       audio_en,
  output logic [7:0] env_level,
  output logic [2:0] env_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [8:0]  ATK_STEP9 = 9'(ATTACK_STEP);
  localparam logic [8:0]  DEC_FLOOR = 9'(SUSTAIN_LVL + DECAY_STEP);
  localparam logic [7:0]  SUS_LVL8  = 8'(SUSTAIN_LVL);
  localparam logic [7:0]  DEC_STEP8 = 8'(DECAY_STEP);
  localparam logic [7:0]  REL_STEP8 = 8'(RELEASE_STEP);

  env_t        state;
  logic [7:0]  level;
  logic        gate_m, gate_s, tone_r;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [8:0]  attack_sum;
  logic [7:0]  sample;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty;

  assign env_state = state;
  assign env_level = level;

  // gate comes straight from the switch logic, so it gets a two-flop synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_m <= 1'b0;
      gate_s <= 1'b0;
      tone_r <= 1'b0;
    end else begin
      gate_m <= gate;
      gate_s <= gate_m;
      tone_r <= tone_in;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 16'd1;
  end

  assign attack_sum = {1'b0, level} + ATK_STEP9;

  // NOTE: non-blocking assignments, so every branch below reads the pre-tick
  // level/state; audio_en is written alongside each transition out of/into IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      level    <= '0;
      audio_en <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (gate_s) begin
            state    <= ATTACK;
            audio_en <= 1'b1;
          end
        end
        ATTACK: begin
          if (!gate_s) state <= RELEASE;
          else if (attack_sum >= 9'd255) begin
            level <= 8'hFF;
            state <= DECAY;
          end else level <= attack_sum[7:0];
        end
        DECAY: begin
          if (!gate_s) state <= RELEASE;
          else if ({1'b0, level} <= DEC_FLOOR) begin
            level <= SUS_LVL8;
            state <= SUSTAIN;
          end else level <= level - DEC_STEP8;
        end
        SUSTAIN: begin
          level <= SUS_LVL8;
          if (!gate_s) state <= RELEASE;
        end
        RELEASE: begin
          if (gate_s) state <= ATTACK;
          else if (level <= REL_STEP8) begin
            level    <= '0;
            state    <= IDLE;
            audio_en <= 1'b0;
          end else level <= level - REL_STEP8;
        end
        default: begin
          state    <= IDLE;
          level    <= '0;
          audio_en <= 1'b0;
        end
      endcase
    end
  end

  assign sample = tone_r ? level : 8'd0;

  // duty only reloads at the period boundary, so a period is never cut short
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) duty <= sample;
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_tone_env_pwm.sv
// Directed bench for tone_env_pwm: envelope tables on a fast-tick instance,
// PWM duty counting, async reset, and saturation on a second instance.
module tb_tone_env_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tone_in = 1'b1;
  logic       gate_a = 1'b0;
  logic       gate_b = 1'b0;
  logic       pwm_a, en_a, pwm_b, en_b;
  logic [7:0] lvl_a, lvl_b;
  logic [2:0] st_a, st_b;

  int passed = 0;
  int total  = 0;
  int edge_n;

  always #5 clk = ~clk;

  // posedges since the last reset release; PWM counter equals edge_n mod 256
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  tone_env_pwm #(.TICK_DIV(4), .ATTACK_STEP(64), .DECAY_STEP(16),
                 .SUSTAIN_LVL(160), .RELEASE_STEP(32)) dut_a (
    .clk(clk), .rst(rst), .tone_in(tone_in), .gate(gate_a),
    .pwm_out(pwm_a), .audio_en(en_a), .env_level(lvl_a), .env_state(st_a));

  tone_env_pwm #(.TICK_DIV(4), .ATTACK_STEP(255), .DECAY_STEP(1),
                 .SUSTAIN_LVL(255), .RELEASE_STEP(200)) dut_b (
    .clk(clk), .rst(rst), .tone_in(tone_in), .gate(gate_b),
    .pwm_out(pwm_b), .audio_en(en_b), .env_level(lvl_b), .env_state(st_b));

  typedef struct {
    bit do_rst;
    bit g;
    int st;
    int lvl;
    bit en;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // envelope ticks land on every 4th posedge after reset release
  task automatic step_tick();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_a) highs++;
    end
  endtask

  initial begin
    int highs;
    int waited;
    int b_st[7]  = '{1, 2, 3, 3, 4, 4, 0};
    int b_lvl[7] = '{0, 255, 255, 255, 255, 55, 0};
    bit b_g[7]   = '{1, 1, 1, 1, 0, 0, 0};
    bit b_en[7]  = '{1, 1, 1, 1, 1, 1, 0};

    // full ADSR with gate held, then release to IDLE
    vq.push_back('{1, 1, 1,   0, 1});
    vq.push_back('{0, 1, 1,  64, 1});
    vq.push_back('{0, 1, 1, 128, 1});
    vq.push_back('{0, 1, 1, 192, 1});
    vq.push_back('{0, 1, 2, 255, 1});
    vq.push_back('{0, 1, 2, 239, 1});
    vq.push_back('{0, 1, 2, 223, 1});
    vq.push_back('{0, 1, 2, 207, 1});
    vq.push_back('{0, 1, 2, 191, 1});
    vq.push_back('{0, 1, 2, 175, 1});
    vq.push_back('{0, 1, 3, 160, 1});
    vq.push_back('{0, 1, 3, 160, 1});
    vq.push_back('{0, 0, 4, 160, 1});
    vq.push_back('{0, 0, 4, 128, 1});
    vq.push_back('{0, 0, 4,  96, 1});
    vq.push_back('{0, 0, 4,  64, 1});
    vq.push_back('{0, 0, 4,  32, 1});
    vq.push_back('{0, 0, 0,   0, 0});
    vq.push_back('{0, 0, 0,   0, 0});
    // early release from ATTACK, then retrigger at 96
    vq.push_back('{1, 1, 1,   0, 1});
    vq.push_back('{0, 1, 1,  64, 1});
    vq.push_back('{0, 1, 1, 128, 1});
    vq.push_back('{0, 0, 4, 128, 1});
    vq.push_back('{0, 0, 4,  96, 1});
    vq.push_back('{0, 1, 1,  96, 1});
    vq.push_back('{0, 1, 1, 160, 1});
    vq.push_back('{0, 1, 1, 224, 1});
    vq.push_back('{0, 1, 2, 255, 1});

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].do_rst) begin
        gate_a = 1'b0;
        do_reset();
      end
      gate_a = vq[i].g;
      step_tick();
      check($sformatf("v%0d_state", i), int'(st_a), vq[i].st);
      check($sformatf("v%0d_level", i), int'(lvl_a), vq[i].lvl);
      check($sformatf("v%0d_en", i), int'(en_a), int'(vq[i].en));
    end

    // finish decay into SUSTAIN and let the PWM settle
    repeat (6) step_tick();
    check("sustain_state", int'(st_a), 3);
    check("sustain_level", int'(lvl_a), 160);
    repeat (520) @(negedge clk);
    count_high(256, highs);
    check("pwm_high_160", highs, 160);

    // drop tone mid-period: old duty holds until the boundary
    waited = 0;
    while ((edge_n % 256) != 100 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("align_wait_ok", int'(waited < 300), 1);
    tone_in = 1'b0;
    count_high(156, highs);
    check("pwm_tail_old_duty", highs, 60);
    count_high(256, highs);
    check("pwm_tone0_silent", highs, 0);

    // asynchronous reset while the output is driving high
    tone_in = 1'b1;
    waited = 0;
    while (!pwm_a && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("pwm_high_before_rst", int'(pwm_a), 1);
    rst = 1'b1;
    #1;
    check("rst_pwm", int'(pwm_a), 0);
    check("rst_en", int'(en_a), 0);
    check("rst_level", int'(lvl_a), 0);
    check("rst_state", int'(st_a), 0);
    @(negedge clk);
    rst = 1'b0;
    step_tick();
    check("restart_state", int'(st_a), 1);
    check("restart_level", int'(lvl_a), 0);

    // saturation corners on the second instance
    gate_a = 1'b0;
    gate_b = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      gate_b = b_g[i];
      step_tick();
      check($sformatf("b%0d_state", i), int'(st_b), b_st[i]);
      check($sformatf("b%0d_level", i), int'(lvl_b), b_lvl[i]);
      check($sformatf("b%0d_en", i), int'(en_b), int'(b_en[i]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
